cpu_mem_arbiter: RTL and testbench

CPU_MEM_ARBITER -- requirements
Module: cpu_mem_arbiter

---
 rtl/cpu_mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_cpu_mem_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_arbiter.sv
// rtl/cpu_mem_arbiter.sv - two-port (inst/data) to single memory port arbiter, one outstanding transaction
//
// Purpose:
//   Multiplexes an instruction-side and a data-side request port onto one
//   shared memory port. Requests are accepted in IDLE, with the fixed winner
//   chosen by DATA_PRIO when both ports request together. The accepted request
//   is latched and presented on the memory side until mem_addr_ok. The block
//   then waits for mem_data_ok and routes that response to the owning port.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   inst_req/wr/size/addr/wdata     instruction-side request
//   inst_addr_ok/data_ok/rdata      instruction-side accept / response
//   data_*                          data-side mirror of the inst_* ports
//   mem_req/wr/size/addr/wdata      shared memory request (from latched fields)
//   mem_addr_ok/data_ok/rdata       shared memory accept / response

module cpu_mem_arbiter #(
    parameter int DATA_PRIO = 1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state;
    logic        owner;        // 0 = inst, 1 = data
    logic        lat_wr;
    logic [1:0]  lat_size;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        mem_req_q;

    logic        idle;
    logic        grant_inst;
    logic        grant_data;
    logic        resp_done;

    // Reset is folded in so no accept is ever signalled while reset is held.
    assign idle = (state == S_IDLE) && !reset;

    generate
        if (DATA_PRIO != 0) begin : g_data_prio
            assign grant_data = idle && data_req;
            assign grant_inst = idle && inst_req && !data_req;
        end else begin : g_inst_prio
            assign grant_inst = idle && inst_req;
            assign grant_data = idle && data_req && !inst_req;
        end
    endgenerate

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;

    // Response is a same-cycle pass-through of the memory response.
    assign resp_done    = (state == S_RESP) && mem_data_ok && !reset;
    assign inst_data_ok = resp_done && !owner;
    assign data_data_ok = resp_done && owner;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    assign mem_req   = mem_req_q;
    assign mem_wr    = lat_wr;
    assign mem_size  = lat_size;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            owner     <= 1'b0;
            lat_wr    <= 1'b0;
            lat_size  <= 2'd0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            mem_req_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_inst || grant_data) begin
                        owner     <= grant_data;
                        lat_wr    <= grant_data ? data_wr    : inst_wr;
                        lat_size  <= grant_data ? data_size  : inst_size;
                        lat_addr  <= grant_data ? data_addr  : inst_addr;
                        lat_wdata <= grant_data ? data_wdata : inst_wdata;
                        mem_req_q <= 1'b1;
                        state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    // Latched fields stay untouched until the memory accepts.
                    if (mem_addr_ok) begin
                        mem_req_q <= 1'b0;
                        state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (mem_data_ok) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    mem_req_q <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb/tb_cpu_mem_arbiter.sv - directed self-checking bench for cpu_mem_arbiter

module tb_cpu_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    cpu_mem_arbiter #(.DATA_PRIO(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // One single-port transaction with the memory accepting after adly extra
    // REQ cycles and responding after ddly extra RESP cycles.
    task automatic do_txn(input bit port, input logic [31:0] addr, input bit wr,
                          input int adly, input int ddly);
        logic [31:0] exp_rd;
        logic        granted;
        exp_rd  = addr ^ 32'hA5A5_5A5A;
        granted = 1'b0;
        if (port) begin
            data_req = 1'b1; data_wr = wr; data_addr = addr; data_wdata = ~addr; data_size = 2'd2;
        end else begin
            inst_req = 1'b1; inst_wr = wr; inst_addr = addr; inst_wdata = ~addr; inst_size = 2'd2;
        end
        for (int k = 0; k < 4; k++) begin
            #1;
            if (port ? data_addr_ok : inst_addr_ok) begin
                granted = 1'b1;
                break;
            end
            cyc();
        end
        check("mix_grant", {31'd0, granted}, 32'd1);
        cyc();
        data_req = 1'b0; inst_req = 1'b0;
        #1;
        check("mix_mem_addr", mem_addr, addr);
        check("mix_mem_wr", {31'd0, mem_wr}, {31'd0, wr});
        repeat (adly) cyc();
        mem_addr_ok = 1'b1;
        cyc();
        mem_addr_ok = 1'b0;
        repeat (ddly) cyc();
        mem_data_ok = 1'b1;
        mem_rdata   = exp_rd;
        #1;
        check("mix_own_data_ok", {31'd0, port ? data_data_ok : inst_data_ok}, 32'd1);
        check("mix_rdata", port ? data_rdata : inst_rdata, exp_rd);
        check("mix_other_data_ok", {31'd0, port ? inst_data_ok : data_data_ok}, 32'd0);
        cyc();
        mem_data_ok = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
        cyc(); cyc();

        // Reset state, with requests and memory handshakes driven active.
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000; inst_size = 2'd2;
        mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
        #1;
        check("rst_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
        check("rst_data_addr_ok", {31'd0, data_addr_ok}, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_inst_data_ok", {31'd0, inst_data_ok}, 32'd0);
        check("rst_data_data_ok", {31'd0, data_data_ok}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        cyc();
        #1;
        check("rst_hold_mem_req", {31'd0, mem_req}, 32'd0);

        // First grant right after release, then single inst read.
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; reset = 1'b0;
        #1;
        check("first_grant_inst", {31'd0, inst_addr_ok}, 32'd1);
        check("first_grant_data", {31'd0, data_addr_ok}, 32'd0);
        cyc();
        inst_req = 1'b0; inst_addr = 32'h1234_5678;
        #1;
        check("rd_mem_req", {31'd0, mem_req}, 32'd1);
        check("rd_mem_addr", mem_addr, 32'hBFC0_0000);
        check("rd_mem_size", {30'd0, mem_size}, 32'd2);
        check("rd_mem_wr", {31'd0, mem_wr}, 32'd0);
        mem_addr_ok = 1'b1;
        cyc();
        mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h3C1D_0000;
        #1;
        check("rd_resp_mem_req", {31'd0, mem_req}, 32'd0);
        check("rd_inst_data_ok", {31'd0, inst_data_ok}, 32'd1);
        check("rd_inst_rdata", inst_rdata, 32'h3C1D_0000);
        check("rd_data_data_ok", {31'd0, data_data_ok}, 32'd0);
        cyc();
        mem_data_ok = 1'b0;
        #1;
        check("rd_pulse_end", {31'd0, inst_data_ok}, 32'd0);
        check("rd_idle_mem_req", {31'd0, mem_req}, 32'd0);

        // Spurious memory handshakes in IDLE.
        mem_data_ok = 1'b1; mem_addr_ok = 1'b1;
        #1;
        check("sp_idle_inst_ok", {31'd0, inst_data_ok}, 32'd0);
        check("sp_idle_data_ok", {31'd0, data_data_ok}, 32'd0);
        cyc();
        mem_data_ok = 1'b0; mem_addr_ok = 1'b0;
        #1;
        check("sp_idle_mem_req", {31'd0, mem_req}, 32'd0);

        // Spurious mem_data_ok in REQ.
        data_req = 1'b1; data_addr = 32'h0000_0040; data_size = 2'd0;
        #1;
        check("sp_grant", {31'd0, data_addr_ok}, 32'd1);
        cyc();
        data_req = 1'b0; mem_data_ok = 1'b1;
        #1;
        check("sp_req_data_ok", {31'd0, data_data_ok}, 32'd0);
        check("sp_req_inst_ok", {31'd0, inst_data_ok}, 32'd0);
        cyc();
        mem_data_ok = 1'b0;
        #1;
        check("sp_req_still", {31'd0, mem_req}, 32'd1);
        check("sp_req_size", {30'd0, mem_size}, 32'd0);
        mem_addr_ok = 1'b1;
        cyc();
        mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0000_0011;
        #1;
        check("sp_resp_data_ok", {31'd0, data_data_ok}, 32'd1);
        check("sp_resp_rdata", data_rdata, 32'h0000_0011);
        cyc();
        mem_data_ok = 1'b0;

        // Simultaneous requests: data wins, inst waits.
        inst_req = 1'b1; inst_addr = 32'h0000_0200; inst_size = 2'd2;
        data_req = 1'b1; data_addr = 32'h0000_0100; data_size = 2'd1;
        #1;
        check("sim_data_addr_ok", {31'd0, data_addr_ok}, 32'd1);
        check("sim_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
        cyc();
        data_req = 1'b0;
        #1;
        check("sim_mem_addr", mem_addr, 32'h0000_0100);
        check("sim_req_inst_ok", {31'd0, inst_addr_ok}, 32'd0);
        mem_addr_ok = 1'b1;
        cyc();
        mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hCAFE_0001;
        #1;
        check("sim_resp_inst_ok", {31'd0, inst_addr_ok}, 32'd0);
        check("sim_data_data_ok", {31'd0, data_data_ok}, 32'd1);
        check("sim_inst_data_ok", {31'd0, inst_data_ok}, 32'd0);
        cyc();
        mem_data_ok = 1'b0;
        #1;
        check("sim_inst_late_grant", {31'd0, inst_addr_ok}, 32'd1);
        cyc();
        inst_req = 1'b0;
        #1;
        check("sim_inst_mem_addr", mem_addr, 32'h0000_0200);
        mem_addr_ok = 1'b1;
        cyc();
        mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hCAFE_0002;
        #1;
        check("sim_inst_resp", {31'd0, inst_data_ok}, 32'd1);
        check("sim_inst_rdata", inst_rdata, 32'hCAFE_0002);
        cyc();
        mem_data_ok = 1'b0;

        // Data write with mem_addr_ok delayed 4 cycles.
        data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h8000_1000;
        data_wdata = 32'hDEAD_BEEF; data_size = 2'd2;
        #1;
        check("wr_grant", {31'd0, data_addr_ok}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            data_req = 1'b0; data_wdata = 32'd0; data_addr = 32'd0;
            if (i == 4) mem_addr_ok = 1'b1;
            #1;
            check("wr_mem_req", {31'd0, mem_req}, 32'd1);
            check("wr_mem_addr", mem_addr, 32'h8000_1000);
            check("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
            check("wr_mem_wr", {31'd0, mem_wr}, 32'd1);
            check("wr_mem_size", {30'd0, mem_size}, 32'd2);
        end
        cyc();
        mem_addr_ok = 1'b0;
        #1;
        check("wr_wait_data_ok", {31'd0, data_data_ok}, 32'd0);
        check("wr_resp_mem_req", {31'd0, mem_req}, 32'd0);
        cyc();
        mem_data_ok = 1'b1; mem_rdata = 32'd0;
        #1;
        check("wr_done", {31'd0, data_data_ok}, 32'd1);
        check("wr_inst_quiet", {31'd0, inst_data_ok}, 32'd0);
        cyc();
        mem_data_ok = 1'b0; data_wr = 1'b0;

        // Reset in RESP abandons the transaction.
        inst_req = 1'b1; inst_addr = 32'h0000_2000; inst_size = 2'd2;
        #1;
        check("rr_grant", {31'd0, inst_addr_ok}, 32'd1);
        cyc();
        inst_req = 1'b0; mem_addr_ok = 1'b1;
        cyc();
        mem_addr_ok = 1'b0; reset = 1'b1;
        #1;
        check("rr_mem_req", {31'd0, mem_req}, 32'd0);
        cyc();
        mem_data_ok = 1'b1; mem_rdata = 32'h5555_AAAA;
        #1;
        check("rr_inst_data_ok", {31'd0, inst_data_ok}, 32'd0);
        check("rr_data_data_ok", {31'd0, data_data_ok}, 32'd0);
        cyc();
        reset = 1'b0; inst_req = 1'b1; inst_addr = 32'h0000_3000;
        #1;
        check("rr_late_data_ok", {31'd0, inst_data_ok}, 32'd0);
        check("rr_first_grant", {31'd0, inst_addr_ok}, 32'd1);
        cyc();
        inst_req = 1'b0; mem_data_ok = 1'b0;
        #1;
        check("rr_new_addr", mem_addr, 32'h0000_3000);
        mem_addr_ok = 1'b1;
        cyc();
        mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0BAD_F00D;
        #1;
        check("rr_new_resp", {31'd0, inst_data_ok}, 32'd1);
        check("rr_new_rdata", inst_rdata, 32'h0BAD_F00D);
        cyc();
        mem_data_ok = 1'b0;

        // Back-to-back mixed traffic.
        do_txn(1'b0, 32'h0000_1004, 1'b0, 0, 0);
        do_txn(1'b1, 32'h8000_2008, 1'b1, 2, 0);
        do_txn(1'b1, 32'h8000_200C, 1'b0, 0, 3);
        do_txn(1'b0, 32'h0000_1010, 1'b0, 1, 1);
        do_txn(1'b1, 32'h8000_3000, 1'b0, 3, 2);
        do_txn(1'b0, 32'h0000_1014, 1'b1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
